dispenser_ctrl: RTL and testbench

DISPENSER_CTRL -- requirements
Module: dispenser_ctrl

---
 rtl/dispenser_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_dispenser_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispenser_ctrl.sv
// dispenser_ctrl -- drink vending controller.
//
// Flow: IDLE -> SELECT (choose drink) -> PAY (collect coins) -> PUMP ->
// HEAT (hot drinks only) -> DELIVER -> CHANGE -> IDLE. A sensor fault or a
// coin that would overflow the credit register diverts to an error state
// that times out into CHANGE with a full refund.
//
// Ports:
//   clock, reset_n      sole clock (rising edge), async active-low reset
//   btn                 start button (level, sampled each clock)
//   confirm, sel        latch drink index sel in SELECT (ignored if sel >= N_DRINKS)
//   cancel              abort payment, refund credit
//   coin_valid,         one-cycle coin strobe with its value; there is no
//   coin_value          back-pressure: every strobe is either accepted into
//                       credit (PAY, no overflow) or answered by a one-cycle
//                       coin_reject pulse on the following cycle
//   sensor_err          fault input, honoured in SELECT/PAY/PUMP/HEAT only
//   state               current state code (debug / status)
//   coin_enable, pump,  actuators
//   heater
//   led_red/green/blue  status LEDs
//   coin_reject         one-cycle pulse, coin refused
//   change_valid,       one-cycle change pulse; change_amount is zero
//   change_amount       whenever change_valid is low
//
// All outputs are registered from the next-state decision so they line up
// with the state register and drop to zero the instant reset_n falls.
module dispenser_ctrl #(
    parameter int                            N_DRINKS  = 4,
    parameter int                            CREDIT_W  = 8,
    parameter logic [N_DRINKS*CREDIT_W-1:0]  PRICES    = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter logic [N_DRINKS-1:0]           COLD_MASK = 4'b1000,
    parameter int                            T_SEL     = 100,
    parameter int                            T_PAY     = 100,
    parameter int                            T_PUMP    = 20,
    parameter int                            T_HEAT    = 100,
    parameter int                            T_DELIVER = 20,
    parameter int                            T_ERR     = 60,
    localparam int                           SEL_W     = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                btn,
    input  logic                confirm,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                sensor_err,
    output logic [3:0]          state,
    output logic                coin_enable,
    output logic                pump,
    output logic                heater,
    output logic                led_red,
    output logic                led_green,
    output logic                led_blue,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SELECT     = 4'd1,
        PAY        = 4'd2,
        PUMP       = 4'd3,
        HEAT       = 4'd4,
        DELIVER    = 4'd5,
        ERR_SENSOR = 4'd6,
        ERR_COIN   = 4'd7,
        CHANGE     = 4'd8
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared timer, sized for the longest timed state.
    localparam int T_MAX   = max_int(max_int(max_int(T_SEL, T_PAY), max_int(T_PUMP, T_HEAT)),
                                     max_int(T_DELIVER, T_ERR));
    localparam int TIMER_W = max_int(1, $clog2(T_MAX));

    // "Expires" means the timer sits on the final cycle of the state.
    localparam logic [TIMER_W-1:0] SEL_LAST     = TIMER_W'(T_SEL - 1);
    localparam logic [TIMER_W-1:0] PAY_LAST     = TIMER_W'(T_PAY - 1);
    localparam logic [TIMER_W-1:0] PUMP_LAST    = TIMER_W'(T_PUMP - 1);
    localparam logic [TIMER_W-1:0] HEAT_LAST    = TIMER_W'(T_HEAT - 1);
    localparam logic [TIMER_W-1:0] DELIVER_LAST = TIMER_W'(T_DELIVER - 1);
    localparam logic [TIMER_W-1:0] ERR_LAST     = TIMER_W'(T_ERR - 1);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 coin_enable_q, coin_enable_d;
    logic                 pump_q, pump_d;
    logic                 heater_q, heater_d;
    logic                 led_red_q, led_red_d;
    logic                 led_green_q, led_green_d;
    logic                 led_blue_q, led_blue_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]  change_amount_q, change_amount_d;

    logic [CREDIT_W-1:0]  price;
    logic [CREDIT_W:0]    coin_sum;
    logic                 coin_fits;
    logic                 coin_accept;
    logic [CREDIT_W-1:0]  change_calc;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q + 1'b1;
        credit_d        = credit_q;
        sel_d           = sel_q;
        change_calc     = '0;

        price       = PRICES[int'(sel_q)*CREDIT_W +: CREDIT_W];
        // One extra bit catches credit overflow.
        coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
        coin_fits   = ~coin_sum[CREDIT_W];
        // A fitting coin in PAY is always banked, even on a cycle that
        // leaves PAY; it comes back later as change or refund.
        coin_accept = (state_q == PAY) && coin_valid && coin_fits;
        if (coin_accept) begin
            credit_d = coin_sum[CREDIT_W-1:0];
        end
        coin_reject_d = coin_valid && !coin_accept;

        case (state_q)
            IDLE: begin
                if (btn) state_d = SELECT;
            end
            SELECT: begin
                if (sensor_err) begin
                    state_d = ERR_SENSOR;
                end else if (confirm && (int'(sel) < N_DRINKS)) begin
                    sel_d   = sel;
                    state_d = PAY;
                end else if (timer_q == SEL_LAST) begin
                    state_d = IDLE;
                end
            end
            PAY: begin
                if (sensor_err) begin
                    state_d = ERR_SENSOR;
                end else if (coin_valid && !coin_fits) begin
                    state_d = ERR_COIN;
                end else if (cancel) begin
                    state_d = CHANGE;
                end else if (credit_q >= price) begin
                    state_d = PUMP;
                end else if (!coin_accept && (timer_q == PAY_LAST)) begin
                    // A coin on the last cycle restarts the wait instead.
                    state_d = CHANGE;
                end
            end
            PUMP: begin
                if (sensor_err) begin
                    state_d = ERR_SENSOR;
                end else if (timer_q == PUMP_LAST) begin
                    state_d = COLD_MASK[sel_q] ? DELIVER : HEAT;
                end
            end
            HEAT: begin
                if (sensor_err) begin
                    state_d = ERR_SENSOR;
                end else if (timer_q == HEAT_LAST) begin
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (timer_q == DELIVER_LAST) state_d = CHANGE;
            end
            ERR_SENSOR, ERR_COIN: begin
                if (timer_q == ERR_LAST) state_d = CHANGE;
            end
            CHANGE: begin
                credit_d = '0;
                state_d  = IDLE;
            end
            default: begin
                credit_d = '0;
                state_d  = IDLE;
            end
        endcase

        // Every state entry and every banked coin restart the timer.
        if ((state_d != state_q) || coin_accept) begin
            timer_d = '0;
        end

        // The price is only debited after a completed delivery; every
        // other route into CHANGE refunds the whole (possibly just
        // updated) credit.
        if (state_d == CHANGE) begin
            change_calc = (state_q == DELIVER) ? (credit_q - price) : credit_d;
        end
        change_valid_d  = (state_d == CHANGE) && (change_calc != '0);
        change_amount_d = change_valid_d ? change_calc : '0;

        coin_enable_d = (state_d == PAY);
        pump_d        = (state_d == PUMP);
        heater_d      = (state_d == HEAT);
        led_red_d     = (state_d == HEAT) || (state_d == ERR_SENSOR) || (state_d == ERR_COIN);
        led_green_d   = (state_d == DELIVER) || (state_d == ERR_COIN);
        led_blue_d    = (state_d == PUMP) || (state_d == ERR_SENSOR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            credit_q        <= '0;
            sel_q           <= '0;
            coin_enable_q   <= 1'b0;
            pump_q          <= 1'b0;
            heater_q        <= 1'b0;
            led_red_q       <= 1'b0;
            led_green_q     <= 1'b0;
            led_blue_q      <= 1'b0;
            coin_reject_q   <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            credit_q        <= credit_d;
            sel_q           <= sel_d;
            coin_enable_q   <= coin_enable_d;
            pump_q          <= pump_d;
            heater_q        <= heater_d;
            led_red_q       <= led_red_d;
            led_green_q     <= led_green_d;
            led_blue_q      <= led_blue_d;
            coin_reject_q   <= coin_reject_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
        end
    end

    assign state         = state_q;
    assign coin_enable   = coin_enable_q;
    assign pump          = pump_q;
    assign heater        = heater_q;
    assign led_red       = led_red_q;
    assign led_green     = led_green_q;
    assign led_blue      = led_blue_q;
    assign coin_reject   = coin_reject_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;

endmodule

// File: tb/tb_dispenser_ctrl.sv
// Directed bench for dispenser_ctrl. Five drinks are configured so that an
// out-of-range index (5) fits on the 3-bit sel bus. Price table, drink 0
// in the low byte: d0=30, d1=25, d2=20, d3=15 (cold), d4=35.
module tb_dispenser_ctrl;

    localparam int N  = 5;
    localparam int CW = 8;
    localparam int SW = 3;

    localparam logic [3:0] S_IDLE = 4'd0, S_SELECT = 4'd1, S_PAY = 4'd2, S_PUMP = 4'd3,
                           S_HEAT = 4'd4, S_DELIVER = 4'd5, S_ERRS = 4'd6, S_ERRC = 4'd7,
                           S_CHANGE = 4'd8;

    logic          clock, reset_n;
    logic          btn, confirm, cancel, coin_valid, sensor_err;
    logic [SW-1:0] sel;
    logic [CW-1:0] coin_value;
    logic [3:0]    state;
    logic          coin_enable, pump, heater, led_red, led_green, led_blue;
    logic          coin_reject, change_valid;
    logic [CW-1:0] change_amount;

    int n_checks = 0;
    int n_errors = 0;
    int heater_cnt = 0;
    int change_cnt = 0;
    int n;
    int snap;

    dispenser_ctrl #(
        .N_DRINKS  (N),
        .CREDIT_W  (CW),
        .PRICES    ({8'd35, 8'd15, 8'd20, 8'd25, 8'd30}),
        .COLD_MASK (5'b01000),
        .T_SEL     (100),
        .T_PAY     (100),
        .T_PUMP    (2),
        .T_HEAT    (10),
        .T_DELIVER (2),
        .T_ERR     (60)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .btn           (btn),
        .confirm       (confirm),
        .sel           (sel),
        .cancel        (cancel),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .sensor_err    (sensor_err),
        .state         (state),
        .coin_enable   (coin_enable),
        .pump          (pump),
        .heater        (heater),
        .led_red       (led_red),
        .led_green     (led_green),
        .led_blue      (led_blue),
        .coin_reject   (coin_reject),
        .change_valid  (change_valid),
        .change_amount (change_amount)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitors: count heater-on and change pulses for sticky checks.
    always @(negedge clock) begin
        if (heater === 1'b1) heater_cnt++;
        if (change_valid === 1'b1) change_cnt++;
    end

    function automatic logic [5:0] outs();
        return {coin_enable, pump, heater, led_red, led_green, led_blue};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Counts cycles spent in st starting with the current one (bounded).
    task automatic count_state(input logic [3:0] st, output int cnt);
        cnt = 0;
        while (state === st && cnt < 1000) begin
            cnt++;
            step();
        end
    endtask

    task automatic start_drink(input logic [SW-1:0] s);
        btn = 1'b1;
        step();
        btn = 1'b0;
        confirm = 1'b1;
        sel = s;
        step();
        confirm = 1'b0;
    endtask

    task automatic coin(input logic [CW-1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    initial begin
        reset_n = 1'b0; btn = 0; confirm = 0; sel = '0; cancel = 0;
        coin_valid = 0; coin_value = '0; sensor_err = 0;
        #12;
        chk("reset_state", 32'(state), 32'(S_IDLE));
        chk("reset_outs", 32'(outs()), 0);
        chk("reset_change", 32'({change_valid, change_amount, coin_reject}), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        step();
        chk("idle_after_reset", 32'(state), 32'(S_IDLE));

        // Coin outside PAY is refused; sensor_err in IDLE ignored.
        sensor_err = 1'b1;
        coin(8'd10);
        sensor_err = 1'b0;
        chk("idle_coin_reject", 32'(coin_reject), 1);
        chk("idle_sensor_ignored", 32'(state), 32'(S_IDLE));
        step();
        chk("idle_reject_pulse_end", 32'(coin_reject), 0);

        // Hot drink 1 (25), three 10 coins -> change 5.
        start_drink(3'd1);
        chk("s1_pay", 32'(state), 32'(S_PAY));
        chk("s1_pay_outs", 32'(outs()), 32'(6'b100000));
        coin(8'd10); coin(8'd10); coin(8'd10);
        chk("s1_still_pay", 32'(state), 32'(S_PAY));
        step();
        chk("s1_pump", 32'(state), 32'(S_PUMP));
        chk("s1_pump_outs", 32'(outs()), 32'(6'b010001));
        count_state(S_PUMP, n);
        chk("s1_pump_len", 32'(n), 2);
        chk("s1_heat", 32'(state), 32'(S_HEAT));
        chk("s1_heat_outs", 32'(outs()), 32'(6'b001100));
        count_state(S_HEAT, n);
        chk("s1_heat_len", 32'(n), 10);
        chk("s1_deliver", 32'(state), 32'(S_DELIVER));
        chk("s1_deliver_outs", 32'(outs()), 32'(6'b000010));
        count_state(S_DELIVER, n);
        chk("s1_deliver_len", 32'(n), 2);
        chk("s1_change", 32'(state), 32'(S_CHANGE));
        chk("s1_change_valid", 32'(change_valid), 1);
        chk("s1_change_amt", 32'(change_amount), 5);
        step();
        chk("s1_idle", 32'(state), 32'(S_IDLE));
        chk("s1_change_cleared", 32'({change_valid, change_amount}), 0);

        // Cold drink 3 (15), exact coin -> no heat, no change.
        snap = heater_cnt;
        start_drink(3'd3);
        coin(8'd15);
        step();
        chk("s2_pump", 32'(state), 32'(S_PUMP));
        count_state(S_PUMP, n);
        chk("s2_pump_len", 32'(n), 2);
        chk("s2_skip_heat", 32'(state), 32'(S_DELIVER));
        count_state(S_DELIVER, n);
        chk("s2_deliver_len", 32'(n), 2);
        chk("s2_change", 32'(state), 32'(S_CHANGE));
        chk("s2_no_change", 32'({change_valid, change_amount}), 0);
        chk("s2_heater_never", 32'(heater_cnt - snap), 0);
        step();

        // Coin arriving on the PAY exit cycle is kept and returned.
        start_drink(3'd3);
        coin(8'd15);
        coin(8'd5);
        chk("s3_pump", 32'(state), 32'(S_PUMP));
        count_state(S_PUMP, n);
        count_state(S_DELIVER, n);
        chk("s3_change_amt", 32'({change_valid, change_amount}), 32'({1'b1, 8'd5}));
        step();

        // Cancel refunds credit including the coin in the same cycle.
        start_drink(3'd2);
        coin(8'd10);
        cancel = 1'b1;
        coin_valid = 1'b1; coin_value = 8'd4;
        step();
        cancel = 1'b0; coin_valid = 1'b0; coin_value = '0;
        chk("cancel_change", 32'(state), 32'(S_CHANGE));
        chk("cancel_amt", 32'({change_valid, change_amount}), 32'({1'b1, 8'd14}));
        step();

        // Credit 250 + 10 overflows -> ERR_COIN, full refund.
        start_drink(3'd0);
        coin(8'd250);
        chk("s4_pay_250", 32'(state), 32'(S_PAY));
        coin(8'd10);
        chk("s4_err_coin", 32'(state), 32'(S_ERRC));
        chk("s4_coin_reject", 32'(coin_reject), 1);
        chk("s4_err_outs", 32'(outs()), 32'(6'b000110));
        count_state(S_ERRC, n);
        chk("s4_err_len", 32'(n), 60);
        chk("s4_refund", 32'({change_valid, change_amount}), 32'({1'b1, 8'd250}));
        step();

        // Sensor fault while heating, credit 30 refunded.
        start_drink(3'd1);
        coin(8'd30);
        step();
        count_state(S_PUMP, n);
        chk("s5_heat", 32'(state), 32'(S_HEAT));
        sensor_err = 1'b1;
        step();
        sensor_err = 1'b0;
        chk("s5_err_sensor", 32'(state), 32'(S_ERRS));
        chk("s5_err_outs", 32'(outs()), 32'(6'b000101));
        count_state(S_ERRS, n);
        chk("s5_err_len", 32'(n), 60);
        chk("s5_refund", 32'({change_valid, change_amount}), 32'({1'b1, 8'd30}));
        step();

        // Out-of-range selection ignored; SELECT times out after 100 cycles.
        btn = 1'b1;
        step();
        btn = 1'b0;
        chk("s6_select", 32'(state), 32'(S_SELECT));
        confirm = 1'b1; sel = 3'd5;
        step();
        confirm = 1'b0;
        chk("s6_bad_sel_ignored", 32'(state), 32'(S_SELECT));
        count_state(S_SELECT, n);
        chk("s6_select_len", 32'(n + 1), 100);
        chk("s6_timeout_idle", 32'(state), 32'(S_IDLE));

        // PAY expires 100 cycles after the last coin, refund 10.
        start_drink(3'd1);
        step(); step(); step();
        chk("s7_pay_wait", 32'(state), 32'(S_PAY));
        coin(8'd10);
        count_state(S_PAY, n);
        chk("s7_pay_len", 32'(n), 100);
        chk("s7_refund", 32'({change_valid, change_amount}), 32'({1'b1, 8'd10}));
        step();

        // Asynchronous reset in PUMP: immediate IDLE, no change pulse.
        snap = change_cnt;
        start_drink(3'd3);
        coin(8'd15);
        step();
        chk("s8_pump", 32'(state), 32'(S_PUMP));
        #2;
        reset_n = 1'b0;
        #1;
        chk("s8_async_state", 32'(state), 32'(S_IDLE));
        chk("s8_async_outs", 32'(outs()), 0);
        chk("s8_async_pulses", 32'({change_valid, change_amount, coin_reject}), 0);
        step(); step();
        reset_n = 1'b1;
        step(); step();
        chk("s8_idle_after", 32'(state), 32'(S_IDLE));
        chk("s8_no_change_pulse", 32'(change_cnt - snap), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
